// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-strobe input and framed-payload output bundle for uart_frame_parser
//
// Signals:
//   i_rx_data     [7:0]               received byte, meaningful only while i_rx_valid=1
//   i_rx_valid                        one-cycle byte strobe from the UART receiver
//   o_frame_data  [MAX_PAYLOAD*8-1:0] payload of the last good frame, byte k at [8k+7:8k]
//   o_frame_len   [7:0]               payload length of the last good frame
//   o_frame_valid                     one-cycle pulse per delivered good frame
//   o_frame_err                       one-cycle pulse per aborted frame
//   o_err_code    [1:0]               1=bad LEN, 2=checksum, 3=timeout; held until next error
// Modports:
//   master : upstream side, drives the byte strobe and observes the frame outputs
//   slave  : parser side, samples the byte strobe and drives the frame outputs
interface uart_frame_parser_if #(
  parameter int MAX_PAYLOAD = 16
);
  logic [7:0]               i_rx_data;
  logic                     i_rx_valid;
  logic [MAX_PAYLOAD*8-1:0] o_frame_data;
  logic [7:0]               o_frame_len;
  logic                     o_frame_valid;
  logic                     o_frame_err;
  logic [1:0]               o_err_code;

  modport master (
    output i_rx_data,
    output i_rx_valid,
    input  o_frame_data,
    input  o_frame_len,
    input  o_frame_valid,
    input  o_frame_err,
    input  o_err_code
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_valid,
    output o_frame_data,
    output o_frame_len,
    output o_frame_valid,
    output o_frame_err,
    output o_err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles HEAD0 HEAD1 LEN payload[LEN] CHK frames from a UART byte stream
//
// Ports:
//   i_clk_sys  system clock
//   i_rst_n    asynchronous active-low reset
//   bus        uart_frame_parser_if.slave: byte strobe in, frame data/len/valid/err/code out
// Frames are verified with an 8-bit wrap-around sum over LEN and payload; a good frame
// updates o_frame_data/o_frame_len and pulses o_frame_valid, any abort pulses o_frame_err.
module uart_frame_parser #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    MAX_PAYLOAD = 16,
  parameter logic [DATA_WIDTH-1:0] HEAD0       = 8'h55,
  parameter logic [DATA_WIDTH-1:0] HEAD1       = 8'hAA,
  parameter int                    CLK_FRE     = 50,
  parameter int                    TIMEOUT_US  = 2000
) (
  input logic                i_clk_sys,
  input logic                i_rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int                    TO_CYC  = CLK_FRE * TIMEOUT_US;
  localparam int                    TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TO_CYC - 1);
  localparam int                    BUF_W   = MAX_PAYLOAD * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD1,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t                state_q,       state_d;
  logic [DATA_WIDTH-1:0] len_q,         len_d;
  logic [DATA_WIDTH-1:0] sum_q,         sum_d;
  logic [DATA_WIDTH-1:0] cnt_q,         cnt_d;
  logic [BUF_W-1:0]      buf_q,         buf_d;
  logic [TO_W-1:0]       to_cnt_q,      to_cnt_d;
  logic [BUF_W-1:0]      frame_data_q,  frame_data_d;
  logic [DATA_WIDTH-1:0] frame_len_q,   frame_len_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q,   frame_err_d;
  logic [1:0]            err_code_q,    err_code_d;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    to_cnt_d      = to_cnt_q;
    frame_data_d  = frame_data_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;

    if (bus.i_rx_valid) begin
      // An accepted byte always restarts the gap timer, even on the expiry cycle.
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_rx_data == HEAD0) state_d = S_HEAD1;
        end
        S_HEAD1: begin
          // A repeated HEAD0 may be the real start of a frame, so keep waiting for HEAD1.
          if (bus.i_rx_data == HEAD1)      state_d = S_LEN;
          else if (bus.i_rx_data != HEAD0) state_d = S_IDLE;
        end
        S_LEN: begin
          if (bus.i_rx_data == '0 || bus.i_rx_data > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_IDLE;
          end else begin
            len_d   = bus.i_rx_data;
            sum_d   = bus.i_rx_data;
            cnt_d   = '0;
            // Clearing here keeps bytes of a longer earlier frame out of the upper lanes.
            buf_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (cnt_q == DATA_WIDTH'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_rx_data;
          end
          sum_d = sum_q + bus.i_rx_data;
          cnt_d = cnt_q + DATA_WIDTH'(1);
          if (cnt_d == len_q) state_d = S_CHK;
        end
        S_CHK: begin
          if (bus.i_rx_data == sum_q) begin
            frame_data_d  = buf_q;
            frame_len_d   = len_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = S_IDLE;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      to_cnt_q      <= '0;
      frame_data_q  <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      to_cnt_q      <= to_cnt_d;
      frame_data_q  <= frame_data_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign bus.o_frame_data  = frame_data_q;
  assign bus.o_frame_len   = frame_len_q;
  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_frame_err   = frame_err_q;
  assign bus.o_err_code    = err_code_q;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver and consumes its received-byte output and its one-cycle done pulse.
- Assembles bytes into framed command packets: HEAD0, HEAD1, LEN, payload[LEN], CHK.
- Delivers each verified payload as a parallel word with a one-cycle valid pulse.
- Reports framing, length, checksum and inter-byte timeout errors as a pulse plus an error code.

Parameters:
- DATA_WIDTH, 8, bits per byte; the block is fixed at 8 and any other value is unsupported.
- MAX_PAYLOAD, 16, maximum payload bytes per frame, range 1..255.
- HEAD0, 8'h55, first header byte.
- HEAD1, 8'hAA, second header byte.
- CLK_FRE, 50, system clock frequency in MHz.
- TIMEOUT_US, 2000, maximum allowed gap between bytes inside a frame, in microseconds.

Ports:
- i_clk_sys  input  1  system clock
- i_rst_n  input  1  global reset
- i_rx_data  input  8  received byte; valid only when i_rx_valid=1
- i_rx_valid  input  1  one-cycle byte strobe from the UART receiver
- o_frame_data  output  MAX_PAYLOAD*8  payload; byte k occupies bits [8k+7:8k]
- o_frame_len  output  8  payload length of the last good frame
- o_frame_valid  output  1  one-cycle pulse: a good frame has been delivered
- o_frame_err  output  1  one-cycle pulse: the frame was aborted
- o_err_code  output  2  1=bad LEN, 2=checksum mismatch, 3=timeout; held until the next error

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk_sys. On reset all outputs go to 0, the state goes to S_IDLE, and the payload buffer, checksum accumulator, byte counter and timeout counter clear. Asserting reset mid-frame discards the partial frame and produces no pulse.
- A byte is accepted only in a cycle with i_rx_valid=1; i_rx_data is ignored otherwise. Back-to-back strobes on consecutive cycles must be accepted.
- States:
  - S_IDLE: byte==HEAD0 -> S_HEAD1; any other byte is ignored.
  - S_HEAD1: byte==HEAD1 -> S_LEN; byte==HEAD0 -> stay in S_HEAD1; else -> S_IDLE. No error is raised in this state.
  - S_LEN: LEN==0 or LEN>MAX_PAYLOAD -> error code 1, go to S_IDLE. Otherwise latch LEN, set sum=LEN, cnt=0, go to S_PAYLOAD.
  - S_PAYLOAD: store the byte at index cnt, sum=sum+byte (mod 256), cnt=cnt+1. When cnt reaches LEN -> S_CHK.
  - S_CHK: if byte==sum, load the buffer into o_frame_data, load LEN into o_frame_len, pulse o_frame_valid, go to S_IDLE. Otherwise error code 2, go to S_IDLE.
- Latency: o_frame_valid or o_frame_err asserts on the clock edge after the cycle in which the terminating byte strobe is sampled, and lasts exactly 1 cycle.
- Output data:
  - o_frame_data and o_frame_len change only on a good frame and are held until the next good frame.
  - Unused upper bytes beyond LEN are forced to 0.
  - Errors never modify o_frame_data or o_frame_len.
- Payload buffer: cleared to 0 on entry to S_PAYLOAD, so stale bytes from a longer earlier frame cannot leak.
- Timeout:
  - TO_CYC = CLK_FRE*TIMEOUT_US; counter width is $clog2(TO_CYC+1).
  - The counter is held at 0 in S_IDLE, cleared on every accepted byte, and increments otherwise.
  - When it reaches TO_CYC-1 with no strobe in that cycle: error code 3, go to S_IDLE.
  - If a strobe coincides with expiry, the byte wins: the counter clears and the byte is processed normally.
- The checksum is an 8-bit wrap-around sum over LEN plus the payload bytes; the header bytes are excluded.
- Error handling: any error pulses o_frame_err and updates o_err_code in the same cycle. The parser returns to S_IDLE and does not re-scan the offending byte as a header.
- o_frame_valid and o_frame_err are never high in the same cycle.

Test Plan:
- Good frame: feed 55 AA 03 11 22 33 69 -> one o_frame_valid pulse, o_frame_len=3, o_frame_data[23:0]=24'h332211, upper bits 0, o_frame_err stays 0.
- Bad checksum: feed 55 AA 02 01 02 00 -> o_frame_err pulse with o_err_code=2. o_frame_data and o_frame_len keep the values from the previous good frame.
- Bad length (MAX_PAYLOAD=16): feed 55 AA 11 -> o_frame_err, o_err_code=1. A following 55 AA 01 7E 7F -> good frame with o_frame_data[7:0]=8'h7E.
- Header resync: feed 12 55 55 AA 01 05 06 -> exactly one valid frame, payload 8'h05, and no error pulse.
- Timeout (CLK_FRE=1, TIMEOUT_US=100 for simulation): feed 55 AA 02 01, then idle for 100 cycles -> o_frame_err, o_err_code=3. Repeat with the next byte arriving exactly on the expiry cycle -> no error, and the frame completes.
- Reset mid-frame: feed 55 AA 04 01 02, pulse i_rst_n low -> all outputs 0. Then 55 AA 01 09 0A -> a valid frame, with no pulses carried over from the aborted frame.
